lsu_byte_sequencer: RTL and testbench
=====================================

Name: lsu_byte_sequencer

Overview:
Load/store initiator that sits between the MEM pipeline stage and a byte-wide data memory port. It accepts one 32-bit RISC-V load/store request (LB/LH/LW/LBU/LHU/SB/SH/SW, selected by fun3). It then issues the 1, 2 or 4 single-byte accesses sequentially in little-endian order, lowest address first. For loads it assembles the bytes and sign/zero-extends the result. It returns a one-cycle response and back-pressures the pipeline through req_ready.

Parameters:
ADDR_W, 8, byte-address width of the request and the memory port; addresses wrap modulo 2^ADDR_W.

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request (IDLE only)
req_we  in  1  1 = store, 0 = load
req_fun3  in  3  RISC-V funct3 access size/extension code
req_addr  in  ADDR_W  byte address of the access
req_wdata  in  32  store data; bits [7:0] go to the lowest address
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load result; 0 for stores and invalid codes
resp_fault  out  1  access rejected (see Optional Feature)
mem_en  out  1  byte access active this cycle
mem_we  out  1  byte write strobe
mem_addr  out  ADDR_W  byte address
mem_wdata  out  8  write byte
mem_rdata  in  8  read byte, combinational from mem_addr in the same cycle

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- State machine: IDLE, XFER, DONE.
  - Reset forces IDLE, byte index 0 and resp_rdata = 0.
  - Reset values: req_ready = 1; resp_valid, resp_fault, mem_en, mem_we, mem_wdata and mem_addr all 0.
- IDLE:
  - req_ready = 1; memory outputs are idle.
  - On req_valid, latch we, fun3, addr and wdata, set index i = 0 and set last = 0/1/3 for byte/half/word.
  - Valid load codes: 000, 001, 010, 100, 101. Valid store codes: 000, 001, 010.
  - Valid code → XFER. Invalid code → DONE directly, with no memory access.
- XFER:
  - req_ready = 0, mem_en = 1, mem_addr = addr + i (wraps), mem_we = we, mem_wdata = wdata[8i+7:8i].
  - On a load, mem_rdata is captured into lane i at the rising edge.
  - If i == last → DONE; otherwise i++.
- DONE:
  - resp_valid = 1 for exactly one cycle.
  - resp_rdata is registered and holds until the next DONE. The new value is applied at DONE entry.
  - Load extension: LB sign-extends bit 7; LH sign-extends bit 15; LBU/LHU zero-extend; LW is taken as is.
  - Stores and invalid codes give resp_rdata = 0.
  - Next state is IDLE. A request cannot be accepted in DONE (req_ready = 0).
- Latency: with the accept edge as cycle 0, byte accesses occupy cycles 1..n (n = 1/2/4) and resp_valid is asserted in cycle n+1. An LW responds at cycle 5. Back-to-back throughput is one request per n+2 cycles.
- Address wrap: a word at addr 255 (ADDR_W = 8) accesses 255, 0, 1, 2.
- Reset mid-operation: return to IDLE immediately and drop mem_en. Store bytes already written stay written; no response is produced.
- req_* inputs are ignored outside IDLE. Latched values are unaffected by later input changes.

Optional Feature:
Macro: MISALIGN_TRAP_EN.
- Defined: a valid halfword access with addr[0] = 1, or a valid word access with addr[1:0] != 0, goes IDLE→DONE with no memory access. The response is resp_fault = 1 and resp_rdata = 0. resp_fault is 0 on every other response.
- Undefined: misaligned accesses are performed byte-by-byte as normal and resp_fault is tied to 0.

Test Plan:
1. Memory bytes 0..3 = 01 00 00 00; LW addr 0 → mem_en asserted in cycles 1-4 at addr 0, 1, 2, 3; resp_valid in cycle 5 with resp_rdata = 0x00000001; req_ready low for cycles 1-5.
2. mem[16] = 0x80: LB addr 16 → 0xFFFFFF80; LBU addr 16 → 0x00000080.
3. SH wdata 0x1234BEEF addr 4 → writes 0xEF to 4 and 0xBE to 5; a following LH addr 4 → 0xFFFFBEEF and LHU → 0x0000BEEF.
4. SW 0x11223344 addr 254 → mem[254] = 44, mem[255] = 33, mem[0] = 22, mem[1] = 11; a following LW addr 254 → 0x11223344.
5. Reset and invalid codes:
   - SW 0xAABBCCDD addr 8 with rst_n pulled low during cycle 3 → only mem[8] = DD and mem[9] = CC change; no resp_valid; req_ready = 1 after release.
   - Load with fun3 = 011 → no mem_en; resp_valid in cycle 1 with resp_rdata = 0.
6. With MISALIGN_TRAP_EN, LW addr 2 → no mem_en; resp_fault = 1 and resp_rdata = 0 in cycle 1. Without the macro → four accesses at 2, 3, 4, 5 and resp_fault = 0.

Source files
------------

// File: rtl/lsu_byte_sequencer.sv
// Byte-serial load/store sequencer: splits one RV32 LB/LH/LW/LBU/LHU/SB/SH/SW into
// little-endian single-byte accesses. Optional macro MISALIGN_TRAP_EN faults misaligned half/word.
module lsu_byte_sequencer #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_fun3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  // state  | meaning
  // S_IDLE | ready for a request, memory port idle
  // S_XFER | one byte access per cycle, lane i_q
  // S_DONE | one-cycle response, result already in rdata_q
  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          i_q, i_d, last_q, last_d;
  logic                we_q, we_d, fault_q, fault_d;
  logic [2:0]          fun3_q, fun3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d, rbuf_q, rbuf_d, rdata_q, rdata_d;
  logic                code_ok, misal;
  logic [4:0]          lane;

  function automatic logic [31:0] extend(input logic [31:0] b, input logic [2:0] f3);
    case (f3)
      3'b000:  extend = {{24{b[7]}}, b[7:0]};
      3'b001:  extend = {{16{b[15]}}, b[15:0]};
      3'b010:  extend = b;
      3'b100:  extend = {24'b0, b[7:0]};
      3'b101:  extend = {16'b0, b[15:0]};
      default: extend = 32'b0;
    endcase
  endfunction

  always_comb begin
    if (req_we) code_ok = (req_fun3 == 3'b000) || (req_fun3 == 3'b001) || (req_fun3 == 3'b010);
    else        code_ok = (req_fun3 == 3'b000) || (req_fun3 == 3'b001) || (req_fun3 == 3'b010)
                       || (req_fun3 == 3'b100) || (req_fun3 == 3'b101);
  end

`ifdef MISALIGN_TRAP_EN
  assign misal = code_ok && (((req_fun3[1:0] == 2'b01) && req_addr[0])
                          || ((req_fun3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)));
`else
  assign misal = 1'b0;
`endif

  assign lane = {i_q, 3'b000};

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    last_d    = last_q;
    we_d      = we_q;
    fun3_d    = fun3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rbuf_d    = rbuf_q;
    rdata_d   = rdata_q;
    fault_d   = fault_q;
    req_ready = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'h00;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          fun3_d  = req_fun3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          i_d     = 2'd0;
          rbuf_d  = 32'b0;
          case (req_fun3[1:0])
            2'b01:   last_d = 2'd1;
            2'b10:   last_d = 2'd3;
            default: last_d = 2'd0;
          endcase
          if (code_ok && !misal) begin
            state_d = S_XFER;
          end else begin
            state_d = S_DONE;
            rdata_d = 32'b0;
            fault_d = misal;
          end
        end
      end
      S_XFER: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q + ADDR_W'(i_q);
        mem_wdata = wdata_q[lane +: 8];
        if (!we_q) rbuf_d[lane +: 8] = mem_rdata;
        if (i_q == last_q) begin
          // rbuf_d already holds the final byte captured on this edge
          state_d = S_DONE;
          rdata_d = we_q ? 32'b0 : extend(rbuf_d, fun3_q);
          fault_d = 1'b0;
        end else begin
          i_d = i_q + 2'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q     <= 2'd0;
      last_q  <= 2'd0;
      we_q    <= 1'b0;
      fun3_q  <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'b0;
      rbuf_q  <= 32'b0;
      rdata_q <= 32'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      last_q  <= last_d;
      we_q    <= we_d;
      fun3_q  <= fun3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rbuf_q  <= rbuf_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  assign resp_valid = (state_q == S_DONE);
  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q && (state_q == S_DONE);

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Directed bench for lsu_byte_sequencer with a 256-byte behavioural memory.
module tb_lsu_byte_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_fun3;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem [256];

  int n_chk = 0;
  int n_pass = 0;

  lsu_byte_sequencer #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_fun3(req_fun3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Issue one request accepted at cycle 0, observe cycles 1..10 at negedge.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [7:0] addr, input logic [31:0] wd,
                        input int exp_n, input logic [31:0] exp_rd, input logic exp_fault);
    int nacc = 0, bad_addr = 0, bad_ready = 0, resp_cyc = 0;
    logic [31:0] rd = 32'h0;
    logic        f = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_fun3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_fun3 = ~f3; req_addr = ~addr; req_wdata = ~wd; req_we = ~we;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (req_ready) bad_ready++;
      if (mem_en) begin
        if (mem_addr !== 8'(addr + 8'(nacc))) bad_addr++;
        nacc++;
      end
      if (resp_valid) begin
        resp_cyc = c; rd = resp_rdata; f = resp_fault;
        break;
      end
    end
    chk({tag, " accesses"}, nacc, exp_n);
    chk({tag, " addr order"}, bad_addr, 0);
    chk({tag, " resp cycle"}, resp_cyc, exp_n + 1);
    chk({tag, " ready low"}, bad_ready, 0);
    chk({tag, " rdata"}, rd, exp_rd);
    chk({tag, " fault"}, {31'b0, f}, {31'b0, exp_fault});
    @(negedge clk);
    chk({tag, " pulse 1 cycle"}, {31'b0, resp_valid}, 32'd0);
    chk({tag, " rdata held"}, resp_rdata, exp_rd);
    chk({tag, " ready again"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] exp6;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    mem[0] = 8'h01; mem[16] = 8'h80;
    req_valid = 0; req_we = 0; req_fun3 = 0; req_addr = 0; req_wdata = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst ready", {31'b0, req_ready}, 32'd1);
    chk("rst resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst rdata", resp_rdata, 32'd0);
    chk("rst mem_addr", {24'b0, mem_addr}, 32'd0);
    rst_n = 1'b1;

    do_req("lw0", 1'b0, 3'b010, 8'd0, 32'h0, 4, 32'h0000_0001, 1'b0);
    do_req("lb16", 1'b0, 3'b000, 8'd16, 32'h0, 1, 32'hFFFF_FF80, 1'b0);
    do_req("lbu16", 1'b0, 3'b100, 8'd16, 32'h0, 1, 32'h0000_0080, 1'b0);

    do_req("sh4", 1'b1, 3'b001, 8'd4, 32'h1234_BEEF, 2, 32'h0, 1'b0);
    chk("sh4 mem4", {24'b0, mem[4]}, 32'hEF);
    chk("sh4 mem5", {24'b0, mem[5]}, 32'hBE);
    chk("sh4 mem6", {24'b0, mem[6]}, 32'h00);
    do_req("lh4", 1'b0, 3'b001, 8'd4, 32'h0, 2, 32'hFFFF_BEEF, 1'b0);
    do_req("lhu4", 1'b0, 3'b101, 8'd4, 32'h0, 2, 32'h0000_BEEF, 1'b0);

    do_req("sw254", 1'b1, 3'b010, 8'd254, 32'h1122_3344, 4, 32'h0, 1'b0);
    chk("sw254 mem254", {24'b0, mem[254]}, 32'h44);
    chk("sw254 mem255", {24'b0, mem[255]}, 32'h33);
    chk("sw254 mem0", {24'b0, mem[0]}, 32'h22);
    chk("sw254 mem1", {24'b0, mem[1]}, 32'h11);
    do_req("lw254", 1'b0, 3'b010, 8'd254, 32'h0, 4, 32'h1122_3344, 1'b0);

    // store interrupted by reset in cycle 3
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_fun3 = 3'b010; req_addr = 8'd8; req_wdata = 32'hAABB_CCDD;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst mid mem_en", {31'b0, mem_en}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (resp_valid || mem_en) seen++;
      end
      chk("rst mid no resp", seen, 0);
    end
    chk("rst mid ready", {31'b0, req_ready}, 32'd1);
    chk("rst mid mem8", {24'b0, mem[8]}, 32'hDD);
    chk("rst mid mem9", {24'b0, mem[9]}, 32'hCC);
    chk("rst mid mem10", {24'b0, mem[10]}, 32'h00);
    chk("rst mid mem11", {24'b0, mem[11]}, 32'h00);

    do_req("ld inv011", 1'b0, 3'b011, 8'd0, 32'h0, 0, 32'h0, 1'b0);
    do_req("st inv100", 1'b1, 3'b100, 8'd20, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
    chk("st inv mem20", {24'b0, mem[20]}, 32'h00);

    exp6 = {mem[5], mem[4], mem[3], mem[2]};
`ifdef MISALIGN_TRAP_EN
    do_req("lw2 misalign", 1'b0, 3'b010, 8'd2, 32'h0, 0, 32'h0, 1'b1);
    do_req("lh5 misalign", 1'b0, 3'b001, 8'd5, 32'h0, 0, 32'h0, 1'b1);
`else
    do_req("lw2 misalign", 1'b0, 3'b010, 8'd2, 32'h0, 4, exp6, 1'b0);
    do_req("lh5 misalign", 1'b0, 3'b001, 8'd5, 32'h0, 2, {{16{mem[6][7]}}, mem[6], mem[5]}, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
